mx8_arb: RTL and testbench

- Round-robin arbiter and sequencer for one shared 8:1 gated mux: 8 requesters contend for a single shared output line.
- Drives the mux select lines and the active-high gate disable (gate=1 forces the mux output to 0).
- Provides hold (burst) limiting and a programmable turnaround gap so two sources never drive back-to-back without an idle gap.
- Sits between requester logic and the shared mux in the same clock domain.

---
 rtl/mx8_arb_pkg.sv | 9 +
 rtl/rr_pick8.sv | 19 +
 rtl/mx8_arb.sv | 96 +++++++++
 tb/tb_mx8_arb.sv | 116 +++++++++++
 4 files changed

// File: rtl/mx8_arb_pkg.sv
// mx8_arb_pkg: shared encodings and sizes for the 8-way round-robin mux arbiter.
package mx8_arb_pkg;
    localparam int NREQ = 8;
    localparam int SELW = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_e;
    function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: rotate-priority encoder, first set request at or after ptr (mod 8).
module rr_pick8
    import mx8_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            valid_o,
    output logic [SELW-1:0] idx_o
);
    logic [NREQ-1:0] rot;
    logic [SELW-1:0] off;
    assign rot = NREQ'({req_i, req_i} >> ptr_i);
    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = SELW'(i);
    end
    assign valid_o = |req_i;
    assign idx_o   = ptr_i + off;
endmodule

// File: rtl/mx8_arb.sv
// mx8_arb: round-robin sequencer for a shared 8:1 gated mux with hold limit and turnaround gap.
module mx8_arb
    import mx8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic            sys_clk,
    input  logic            resetl,
    input  logic [NREQ-1:0] req,
    output logic [SELW-1:0] sel,
    output logic            gn,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            preempt
);
    state_e          state_q, state_d;
    logic [SELW-1:0] ptr_q, ptr_d, sel_q, sel_d;
    logic [7:0]      hold_q, hold_d;
    logic [3:0]      turn_q, turn_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            gn_q, gn_d, busy_q, busy_d, pre_q, pre_d;
    logic            pick_v, owner_req, others, at_max, arb;
    logic [SELW-1:0] pick_idx;

    rr_pick8 u_pick (.req_i(req), .ptr_i(ptr_q), .valid_o(pick_v), .idx_o(pick_idx));

    assign owner_req = req[sel_q];
    assign others    = |(req & ~gnt_q);
    assign at_max    = hold_q == 8'(MAX_HOLD);
    // Arbitration runs in IDLE and in the last TURN cycle so a pending grant follows TURN directly.
    assign arb       = state_q == IDLE || (state_q == TURN && turn_q == 4'(TURN_CYC));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        gn_d    = gn_q;
        busy_d  = busy_q;
        pre_d   = 1'b0;
        if (arb) begin
            state_d = pick_v ? GRANT : IDLE;
            gnt_d   = pick_v ? onehot(pick_idx) : '0;
            sel_d   = pick_v ? pick_idx : sel_q;
            gn_d    = !pick_v;
            busy_d  = pick_v;
            hold_d  = pick_v ? 8'd1 : hold_q;
        end else if (state_q == TURN) begin
            turn_d = turn_q + 4'd1;
        end else if (!owner_req || (at_max && others)) begin
            // A release wins over an expiring hold, so the pulse only marks a forced handover.
            state_d = (TURN_CYC > 0) ? TURN : IDLE;
            ptr_d   = sel_q + 3'd1;
            gnt_d   = '0;
            gn_d    = 1'b1;
            busy_d  = TURN_CYC > 0;
            turn_d  = 4'd1;
            pre_d   = owner_req;
        end else if (!at_max) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            gn_q    <= 1'b1;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            gn_q    <= gn_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
        end
    end

    assign sel     = sel_q;
    assign gn      = gn_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign preempt = pre_q;
endmodule

// File: tb/tb_mx8_arb.sv
// tb_mx8_arb: directed scoreboard bench for mx8_arb with MAX_HOLD=4, TURN_CYC=1.
module tb_mx8_arb;
    logic       clk = 1'b0;
    logic       resetl;
    logic [7:0] req;
    logic [2:0] sel;
    logic       gn, busy, preempt;
    logic [7:0] gnt;
    logic [13:0] obs;
    logic [13:0] sb[$];
    int ncmp = 0;
    int nfail = 0;

    mx8_arb #(.MAX_HOLD(4), .TURN_CYC(1)) dut (
        .sys_clk(clk), .resetl(resetl), .req(req), .sel(sel), .gn(gn),
        .gnt(gnt), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;
    assign obs = {gnt, sel, gn, busy, preempt};

    function automatic logic [13:0] f_g(int k);
        return {8'(1 << k), 3'(k), 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [13:0] f_t(int k, logic p);
        return {8'h00, 3'(k), 1'b1, 1'b1, p};
    endfunction
    function automatic logic [13:0] f_i(int k);
        return {8'h00, 3'(k), 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic check(string tag);
        logic [13:0] e;
        if (sb.size() == 0) begin
            nfail++;
            $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
            return;
        end
        e = sb.pop_front();
        ncmp++;
        assert (obs === e) else begin
            nfail++;
            $display("FAIL %s: observed {gnt,sel,gn,busy,pre}=%h expected=%h", tag, obs, e);
            $error("comparison %s", tag);
        end
    endtask

    task automatic step(logic [7:0] r, logic [13:0] e, string tag);
        req = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        #2 resetl = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(f_i(0));
        check("reset");
        resetl = 1'b1;
    endtask

    initial begin
        req = 8'h00;
        resetl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(f_i(0));
        check("por");
        resetl = 1'b1;
        for (int n = 0; n < 10; n++) step(8'h00, f_i(0), "idle");

        for (int n = 0; n < 5; n++) step(8'h08, f_g(3), "single_grant");
        step(8'h00, f_t(3, 1'b0), "single_release");
        step(8'h00, f_i(3), "single_idle");

        do_reset();
        for (int n = 0; n < 9; n++) begin
            for (int j = 0; j < 4; j++) step(8'hFF, f_g(n % 8), "rr_grant");
            step(8'hFF, f_t(n % 8, 1'b1), "rr_preempt");
        end
        step(8'h00, f_i(0), "rr_idle");

        do_reset();
        for (int n = 0; n < 20; n++) step(8'h01, f_g(0), "hold_alone");
        step(8'h21, f_t(0, 1'b1), "late_preempt");
        step(8'h21, f_g(5), "late_grant");
        step(8'h00, f_t(5, 1'b0), "late_release");
        step(8'h00, f_i(5), "late_idle");

        do_reset();
        step(8'h04, f_g(2), "tie_g2");
        for (int n = 0; n < 3; n++) step(8'h44, f_g(2), "tie_hold");
        step(8'h40, f_t(2, 1'b0), "tie_release");
        step(8'h40, f_g(6), "tie_g6");

        do_reset();
        for (int n = 0; n < 3; n++) step(8'h10, f_g(4), "pre_async");
        #3 resetl = 1'b0;
        #1;
        sb.push_back(f_i(0));
        check("async_reset");
        @(posedge clk);
        #1;
        sb.push_back(f_i(0));
        check("reset_held");
        resetl = 1'b1;
        step(8'h11, f_g(0), "post_reset_g0");
        step(8'h11, f_g(0), "post_reset_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
